ccd_wr_sched: RTL and testbench

CCD_WR_SCHED -- requirements
Module: ccd_wr_sched

---
 rtl/ccd_pkg.sv | 30 +++
 rtl/ccd_wr_sched_if.sv | 31 +++
 rtl/ccd_rr_arb.sv | 28 ++
 rtl/ccd_wr_sched.sv | 140 ++++++++++++++
 tb/tb_ccd_wr_sched.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ccd_pkg.sv
// Shared types and constants for the CCD producer-side write scheduler.
// Burst lengths are 11 bits wide and inter-write idle counts are 4 bits wide.
package ccd_pkg;

  localparam int unsigned CCD_LEN_W  = 11;
  localparam int unsigned CCD_IDLE_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_GAP   = 2'd2
  } ccd_arb_state_e;

  // A zero length still moves one word; anything past the burst cap is truncated.
  function automatic logic [CCD_LEN_W-1:0] ccd_clamp_len(
    input logic [CCD_LEN_W-1:0] len,
    input logic [CCD_LEN_W-1:0] max_len
  );
    logic [CCD_LEN_W-1:0] r;
    if (len == '0) begin
      r = CCD_LEN_W'(1);
    end else if (len > max_len) begin
      r = max_len;
    end else begin
      r = len;
    end
    return r;
  endfunction

endpackage

// File: rtl/ccd_wr_sched_if.sv
// Requester and FIFO-write bundle for ccd_wr_sched.
// The slave modport is the scheduler side; the master modport is the requester/FIFO side.
interface ccd_wr_sched_if #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_NUM_REQ    = 4
);
  import ccd_pkg::*;

  logic [P_NUM_REQ-1:0]              I_REQ;
  logic [P_NUM_REQ*CCD_LEN_W-1:0]    I_LEN;
  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] I_DATA;
  logic [CCD_IDLE_W-1:0]             I_IDLE;
  logic                              I_FULL;
  logic [P_NUM_REQ-1:0]              O_GNT;
  logic [P_NUM_REQ-1:0]              O_ACK;
  logic [P_NUM_REQ-1:0]              O_DONE;
  logic                              O_WR_EN;
  logic [P_DATA_WIDTH-1:0]           O_WR_DATA;
  logic                              O_BUSY;

  modport master (
    output I_REQ, I_LEN, I_DATA, I_IDLE, I_FULL,
    input  O_GNT, O_ACK, O_DONE, O_WR_EN, O_WR_DATA, O_BUSY
  );

  modport slave (
    input  I_REQ, I_LEN, I_DATA, I_IDLE, I_FULL,
    output O_GNT, O_ACK, O_DONE, O_WR_EN, O_WR_DATA, O_BUSY
  );

endinterface

// File: rtl/ccd_rr_arb.sv
// Combinational round-robin arbiter: the first requester found when searching
// upward from ptr (wrapping around) receives a one-hot grant.
module ccd_rr_arb #(
  parameter int unsigned P_NUM_REQ = 4,
  parameter int unsigned P_IDX_W   = 2
) (
  input  logic [P_NUM_REQ-1:0] req,
  input  logic [P_IDX_W-1:0]   ptr,
  output logic [P_NUM_REQ-1:0] gnt
);

  logic found;

  // Nested constant loops keep every select index static; i is the distance from ptr.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
      for (int unsigned j = 0; j < P_NUM_REQ; j++) begin
        if (!found && req[j] && (j == ((32'(ptr) + i) % P_NUM_REQ))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ccd_wr_sched.sv
// Producer-side burst scheduler: arbitrates requesters round-robin and streams the
// winner's words into a FIFO, with optional idle gaps and stalls on FIFO full.
module ccd_wr_sched
  import ccd_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_MAX_BURST  = 1024,
  parameter int unsigned P_NUM_REQ    = 4
) (
  input logic          PROD_CLK,
  input logic          PROD_RST_N,
  ccd_wr_sched_if.slave bus
);

  localparam int unsigned IDX_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
  localparam logic [CCD_LEN_W-1:0] MAX_LEN = CCD_LEN_W'(P_MAX_BURST);

  ccd_arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [P_NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [CCD_LEN_W-1:0]    rem_q, rem_d;
  logic [CCD_IDLE_W-1:0]   idle_q, idle_d;
  logic [CCD_IDLE_W-1:0]   gap_q, gap_d;

  logic [P_NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic [IDX_W-1:0]        ptr_next;
  logic [CCD_LEN_W-1:0]    len_sel;
  logic [P_DATA_WIDTH-1:0] data_sel;
  logic                    wr_en;
  logic [P_NUM_REQ-1:0]    ack;

  ccd_rr_arb #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_IDX_W   (IDX_W)
  ) u_arb (
    .req (bus.I_REQ),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    len_sel = '0;
    for (int unsigned j = 0; j < P_NUM_REQ; j++) begin
      if (arb_gnt[j]) begin
        arb_idx = IDX_W'(j);
        len_sel = bus.I_LEN[j*CCD_LEN_W +: CCD_LEN_W];
      end
    end
    ptr_next = (arb_idx == IDX_W'(P_NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
  end

  always_comb begin
    data_sel = '0;
    for (int unsigned j = 0; j < P_NUM_REQ; j++) begin
      if (gnt_q[j]) begin
        data_sel = bus.I_DATA[j*P_DATA_WIDTH +: P_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    rem_d   = rem_q;
    idle_d  = idle_q;
    gap_d   = gap_q;
    wr_en   = (state_q == ARB_WRITE) && !bus.I_FULL;

    case (state_q)
      ARB_IDLE: begin
        if (|bus.I_REQ) begin
          gnt_d   = arb_gnt;
          ptr_d   = ptr_next;
          rem_d   = ccd_clamp_len(len_sel, MAX_LEN);
          idle_d  = bus.I_IDLE;
          state_d = ARB_WRITE;
        end
      end
      ARB_WRITE: begin
        if (wr_en) begin
          if (rem_q > CCD_LEN_W'(1)) begin
            rem_d = rem_q - CCD_LEN_W'(1);
            if (idle_q != '0) begin
              gap_d   = idle_q;
              state_d = ARB_GAP;
            end
          end else begin
            rem_d   = '0;
            gnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_GAP: begin
        // gap_q counts the remaining gap cycles including the current one.
        if (gap_q <= CCD_IDLE_W'(1)) begin
          gap_d   = '0;
          state_d = ARB_WRITE;
        end else begin
          gap_d = gap_q - CCD_IDLE_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge PROD_CLK) begin
    if (!PROD_RST_N) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rem_q   <= '0;
      idle_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rem_q   <= rem_d;
      idle_q  <= idle_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    ack           = gnt_q & {P_NUM_REQ{wr_en}};
    bus.O_GNT     = gnt_q;
    bus.O_ACK     = ack;
    bus.O_DONE    = (rem_q == CCD_LEN_W'(1)) ? ack : '0;
    bus.O_WR_EN   = wr_en;
    bus.O_WR_DATA = (state_q == ARB_WRITE) ? data_sel : '0;
    bus.O_BUSY    = (state_q != ARB_IDLE);
  end

endmodule

// File: tb/tb_ccd_wr_sched.sv
// Directed self-checking bench for ccd_wr_sched with hand-computed cycle offsets
// for writes, done pulses and return to idle.
module tb_ccd_wr_sched;

  localparam int DW = 8;
  localparam int NR = 4;

  logic PROD_CLK   = 1'b0;
  logic PROD_RST_N = 1'b0;

  ccd_wr_sched_if #(.P_DATA_WIDTH(DW), .P_NUM_REQ(NR)) bus ();

  ccd_wr_sched #(
    .P_DATA_WIDTH (DW),
    .P_MAX_BURST  (1024),
    .P_NUM_REQ    (NR)
  ) dut (
    .PROD_CLK   (PROD_CLK),
    .PROD_RST_N (PROD_RST_N),
    .bus        (bus)
  );

  always #5 PROD_CLK = ~PROD_CLK;

  int n_chk = 0;
  int n_bad = 0;

  int          wr_cyc[$];
  logic [3:0]  wr_gnt[$];
  logic [7:0]  wr_dat[$];
  int          done_cyc[$];
  logic [3:0]  done_val;
  int          end_cyc;
  int          ack_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PROD_CLK);
    #2;
  endtask

  task automatic set_len(input int k, input int v);
    bus.I_LEN[k*11 +: 11] = 11'(v);
  endtask

  task automatic set_dat(input int k, input logic [7:0] v);
    bus.I_DATA[k*8 +: 8] = v;
  endtask

  // Called on the first cycle of a granted burst; offset 0 is that cycle.
  task automatic watch(input int budget, input logic [31:0] full_mask);
    logic [31:0] m;
    wr_cyc.delete();
    wr_gnt.delete();
    wr_dat.delete();
    done_cyc.delete();
    done_val = '0;
    end_cyc  = -1;
    ack_bad  = 0;
    for (int i = 0; i < budget; i++) begin
      m = full_mask >> i;
      bus.I_FULL = m[0];
      #1;
      if (bus.O_ACK !== (bus.O_WR_EN ? bus.O_GNT : 4'b0000)) ack_bad++;
      if (bus.O_WR_EN) begin
        wr_cyc.push_back(i);
        wr_gnt.push_back(bus.O_GNT);
        wr_dat.push_back(bus.O_WR_DATA);
      end
      if (bus.O_DONE != '0) begin
        done_cyc.push_back(i);
        done_val = bus.O_DONE;
      end
      if (!bus.O_BUSY) begin
        end_cyc = i;
        break;
      end
      step();
    end
    bus.I_FULL = 1'b0;
    chk("burst_end_within_budget", 32'(end_cyc >= 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=time_limit exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.I_REQ  = '0;
    bus.I_LEN  = '0;
    bus.I_DATA = '0;
    bus.I_IDLE = '0;
    bus.I_FULL = 1'b0;

    // Reset holds everything at zero even with requests pending.
    PROD_RST_N = 1'b0;
    bus.I_REQ  = 4'b1111;
    step();
    step();
    chk("rst_gnt",   bus.O_GNT, 0);
    chk("rst_busy",  bus.O_BUSY, 0);
    chk("rst_wr_en", bus.O_WR_EN, 0);
    chk("rst_ack",   bus.O_ACK, 0);
    chk("rst_done",  bus.O_DONE, 0);
    chk("rst_data",  bus.O_WR_DATA, 0);
    bus.I_REQ  = '0;
    PROD_RST_N = 1'b1;
    step();

    // Single requester, 5 back-to-back writes; request dropped mid-burst.
    bus.I_REQ = 4'b0001;
    set_len(0, 5);
    set_dat(0, 8'hA5);
    bus.I_IDLE = 4'd0;
    step();
    bus.I_REQ = 4'b0000;
    watch(20, 32'h0);
    chk("single_nwr",      wr_cyc.size(), 5);
    chk("single_first",    (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 0);
    chk("single_last",     (wr_cyc.size() > 4) ? wr_cyc[4] : -1, 4);
    chk("single_gnt",      (wr_gnt.size() > 0) ? 32'(wr_gnt[0]) : 32'hFF, 4'b0001);
    chk("single_data",     (wr_dat.size() > 0) ? 32'(wr_dat[0]) : 32'hFFF, 8'hA5);
    chk("single_ndone",    done_cyc.size(), 1);
    chk("single_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 4);
    chk("single_done_val", done_val, 4'b0001);
    chk("single_end",      end_cyc, 5);
    chk("single_ack",      ack_bad, 0);
    chk("single_gnt_clr",  bus.O_GNT, 0);

    // Round robin over four requesters, restart pointer from 0.
    PROD_RST_N = 1'b0;
    step();
    PROD_RST_N = 1'b1;
    for (int k = 0; k < NR; k++) begin
      set_len(k, 2);
      set_dat(k, 8'(8'h10 + k));
    end
    bus.I_IDLE = 4'd0;
    bus.I_REQ  = 4'b1111;
    step();
    for (int b = 0; b < 5; b++) begin
      watch(10, 32'h0);
      chk($sformatf("rr%0d_gnt", b),  (wr_gnt.size() > 0) ? 32'(wr_gnt[0]) : 32'hFF, 32'(1 << (b % 4)));
      chk($sformatf("rr%0d_data", b), (wr_dat.size() > 0) ? 32'(wr_dat[0]) : 32'hFFF, 32'(8'h10 + (b % 4)));
      chk($sformatf("rr%0d_nwr", b),  wr_cyc.size(), 2);
      chk($sformatf("rr%0d_end", b),  end_cyc, 2);
      if (b < 4) begin
        step();
        chk($sformatf("rr%0d_one_idle", b), bus.O_BUSY, 1);
      end else begin
        bus.I_REQ = '0;
        step();
      end
    end

    // Gap of 2 plus a 3-cycle FIFO-full stall on the second write.
    // Mid-burst changes to I_IDLE and I_LEN must not take effect.
    bus.I_REQ = 4'b0001;
    set_len(0, 3);
    bus.I_IDLE = 4'd2;
    step();
    bus.I_REQ  = '0;
    bus.I_IDLE = 4'd0;
    set_len(0, 7);
    watch(40, 32'b111000);
    chk("gap_nack",     wr_cyc.size(), 3);
    chk("gap_w0",       (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 0);
    chk("gap_w1",       (wr_cyc.size() > 1) ? wr_cyc[1] : -1, 6);
    chk("gap_w2",       (wr_cyc.size() > 2) ? wr_cyc[2] : -1, 9);
    chk("gap_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 9);
    chk("gap_ndone",    done_cyc.size(), 1);
    chk("gap_end",      end_cyc, 10);
    chk("gap_ack",      ack_bad, 0);

    // Zero length still writes once.
    bus.I_REQ = 4'b0001;
    set_len(0, 0);
    step();
    bus.I_REQ = '0;
    watch(8, 32'h0);
    chk("len0_nwr",  wr_cyc.size(), 1);
    chk("len0_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 0);
    chk("len0_end",  end_cyc, 1);

    // Maximum encodable length clamps to the 1024-word burst cap.
    bus.I_REQ = 4'b0001;
    set_len(0, 2047);
    step();
    bus.I_REQ = '0;
    watch(1100, 32'h0);
    chk("len2047_nwr",   wr_cyc.size(), 1024);
    chk("len2047_last",  (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : -1, 1023);
    chk("len2047_done",  (done_cyc.size() > 0) ? done_cyc[0] : -1, 1023);
    chk("len2047_ndone", done_cyc.size(), 1);
    chk("len2047_end",   end_cyc, 1024);

    // Reset during an 8-word burst of requester 2, right after its 2nd write.
    bus.I_REQ = 4'b0100;
    set_len(2, 8);
    step();
    chk("rstmid_gnt",  bus.O_GNT, 4'b0100);
    chk("rstmid_w0",   bus.O_WR_EN, 1);
    step();
    chk("rstmid_w1",   bus.O_WR_EN, 1);
    chk("rstmid_nodone_pre", bus.O_DONE, 0);
    PROD_RST_N = 1'b0;
    bus.I_REQ  = 4'b1111;
    step();
    chk("rstmid_gnt0",  bus.O_GNT, 0);
    chk("rstmid_busy0", bus.O_BUSY, 0);
    chk("rstmid_wr0",   bus.O_WR_EN, 0);
    chk("rstmid_ack0",  bus.O_ACK, 0);
    chk("rstmid_done0", bus.O_DONE, 0);
    chk("rstmid_data0", bus.O_WR_DATA, 0);
    PROD_RST_N = 1'b1;
    step();
    chk("rstmid_next_gnt", bus.O_GNT, 4'b0001);
    bus.I_REQ  = '0;
    PROD_RST_N = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
